md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 54 +++++
 rtl/md_calc.sv | 96 +++++++++
 rtl/md_unit.sv | 127 ++++++++++++
 tb/tb_md_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared definitions for the multiply/divide unit: MDOp encodings,
//             FSM state encoding, default busy-cycle constants and small
//             operation-classification helpers.
//  Options  : MD_UNIT_MADD_EN - when defined, madd (7) / maddu (8) are
//             multi-cycle start operations; otherwise they decode as "none".
//  Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  // Operations timed with MULT_CYCLES.
  function automatic logic is_mult_op(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_UNIT_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU);
`endif
    return r;
  endfunction

  // Operations timed with DIV_CYCLES.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Operations that are launched by a start pulse.
  function automatic logic is_start_op(input logic [3:0] op);
    return is_mult_op(op) || is_div_op(op);
  endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
//  Module   : md_calc
//  Purpose  : Combinational 64-bit result {HI,LO} for the latched operation.
//             Handles signed/unsigned multiply, signed/unsigned divide
//             (truncating quotient, remainder signed like the dividend),
//             divide overflow and divide-by-zero (no write).
//  Options  : MD_UNIT_MADD_EN - adds madd/maddu accumulate into {HI,LO}.
//  Ports    : op     - latched operation code
//             a, b   - latched operands
//             hi, lo - current HI/LO (accumulate source, no-write default)
//             result - {HI,LO} to write on completion
//             wr_en  - result is to be written (low for divide by zero)
//  Revision : 1.0 - initial release
// ============================================================================
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        wr_en
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Sign/zero-extended 64-bit products; the low 64 bits of a product of
  // sign-extended operands equal the signed 64-bit product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A single unsigned divider serves both forms: signed divide works on
  // magnitudes and fixes signs afterwards. 0x80000000 / -1 falls out
  // naturally: |a| = 0x80000000, q = 0x80000000, negating it wraps back.
  assign div_signed = (op == MD_DIV);
  assign a_mag      = a[31] ? (32'd0 - a) : a;
  assign b_mag      = b[31] ? (32'd0 - b) : b;
  assign dividend   = div_signed ? a_mag : a;
  // Divisor of zero is replaced so the divider never sees it; the result
  // is discarded through wr_en anyway.
  assign divisor    = (b == 32'd0) ? 32'd1 : (div_signed ? b_mag : b);
  assign quo_mag    = dividend / divisor;
  assign rem_mag    = dividend % divisor;
  assign quo        = (div_signed && (a[31] ^ b[31])) ? (32'd0 - quo_mag) : quo_mag;
  assign rem        = (div_signed && a[31]) ? (32'd0 - rem_mag) : rem_mag;

  always_comb begin
    result = {hi, lo};
    wr_en  = 1'b0;
    case (op)
      MD_MULT: begin
        result = prod_s;
        wr_en  = 1'b1;
      end
      MD_MULTU: begin
        result = prod_u;
        wr_en  = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          result = {rem, quo};
          wr_en  = 1'b1;
        end
      end
`ifdef MD_UNIT_MADD_EN
      MD_MADD: begin
        result = {hi, lo} + prod_s;
        wr_en  = 1'b1;
      end
      MD_MADDU: begin
        result = {hi, lo} + prod_u;
        wr_en  = 1'b1;
      end
`endif
      default: begin
        result = {hi, lo};
        wr_en  = 1'b0;
      end
    endcase
  end

endmodule : md_calc
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO.
//             IDLE/BUSY FSM plus a 4-bit down-counter sets the busy time;
//             HI/LO update only when an operation completes (or at once for
//             mthi/mtlo in IDLE).
//  Options  : MD_UNIT_MADD_EN - enables madd (7) / maddu (8).
//  Params   : MULT_CYCLES (1..15) busy cycles for mult/multu/madd/maddu
//             DIV_CYCLES  (1..15) busy cycles for div/divu
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous active-low reset
//             start - one-cycle request to launch a multi-cycle op
//             MDOp  - operation code (see md_pkg::md_op_e)
//             A, B  - operands rs / rt
//             busy  - registered, high while an operation is in flight
//             HI,LO - architectural HI/LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [3:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  logic [63:0] calc_result;
  logic        calc_wr_en;

  md_calc u_md_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (calc_result),
    .wr_en  (calc_wr_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_start_op(MDOp)) begin
          state_d = ST_BUSY;
          op_d    = MDOp;
          a_d     = A;
          b_d     = B;
          cnt_d   = is_mult_op(MDOp) ? MULT_CNT : DIV_CNT;
        end else if (MDOp == MD_MTHI) begin
          hi_d = A;
        end else if (MDOp == MD_MTLO) begin
          lo_d = A;
        end
      end
      ST_BUSY: begin
        // Counter holds the number of busy cycles still to run, including
        // the current one; the edge that sees 1 completes the operation.
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          if (calc_wr_en) begin
            {hi_d, lo_d} = calc_result;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Self-checking bench for md_unit. The driver issues directed and
//             random operations and pushes expected {HI,LO} and busy length
//             into a queue; a monitor pops and compares on each busy->idle
//             transition. Define MD_UNIT_MADD_EN to exercise madd/maddu.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
  endtask

  // Architectural model: plain 64-bit / 32-bit arithmetic on HI/LO.
  function automatic void ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
    longint          sp;
    longint unsigned up;
    longint unsigned acc;
    int              sa, sb;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = 64'(a) * 64'(b);
    acc = {hi, lo};
    cyc = (op == 3 || op == 4) ? 10 : 5;
    case (op)
      1: {hi, lo} = sp;
      2: {hi, lo} = up;
      3: if (b != 0) begin
           if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
             lo = a; hi = 32'd0;
           end else begin
             sa = a; sb = b;
             lo = sa / sb; hi = sa % sb;
           end
         end
      4: if (b != 0) begin lo = a / b; hi = a % b; end
      7: {hi, lo} = acc + sp;
      8: {hi, lo} = acc + up;
      default: ;
    endcase
  endfunction

  // Monitor: count busy cycles, check HI/LO hold pre-op values while busy,
  // compare against the scoreboard head when busy drops.
  int   mon_cnt = 0;
  logic mon_prev = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      mon_cnt  = 0;
      mon_prev = 1'b0;
    end else begin
      if (busy) begin
        mon_cnt++;
        if (exp_q.size() > 0) begin
          check32("hi_during_busy", HI, exp_q[0].pre_hi);
          check32("lo_during_busy", LO, exp_q[0].pre_lo);
        end
      end else if (mon_prev) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_completion: actual busy drop required none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check32("busy_cycles", 32'(mon_cnt), 32'(e.cycles));
          check32("hi_result", HI, e.hi);
          check32("lo_result", LO, e.lo);
        end
        mon_cnt = 0;
      end
      mon_prev = busy;
    end
  end

  task automatic issue_start(input int op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   cyc;
    @(negedge clk);
    start = 1'b1; MDOp = 4'(op); A = a; B = b;
    #1;
    check32("busy_not_comb", {31'd0, busy}, 32'd0);
    e.pre_hi = m_hi; e.pre_lo = m_lo;
    ref_op(op, a, b, m_hi, m_lo, cyc);
    e.hi = m_hi; e.lo = m_lo; e.cycles = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; MDOp = 4'd0;
  endtask

  task automatic wait_idle();
    int budget = 40;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (busy) begin
      n_total++;
      $display("FAIL busy_timeout: actual busy=1 required busy=0 at %0t", $time);
    end
  endtask

  task automatic move_to(input int op, input logic [31:0] a);
    @(negedge clk);
    MDOp = 4'(op); A = a;
    if (op == 5) m_hi = a; else m_lo = a;
    @(negedge clk);
    MDOp = 4'd0;
    check32("mt_busy", {31'd0, busy}, 32'd0);
    check32("mt_hi", HI, m_hi);
    check32("mt_lo", LO, m_lo);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    logic [31:0] ra, rb;
    #1;
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_hi", HI, 32'd0);
    check32("reset_lo", LO, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // mult on the first edge after reset release
    issue_start(1, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check32("mult_hi_const", HI, 32'hFFFF_FFFF);
    check32("mult_lo_const", LO, 32'hFFFF_FFFA);

    issue_start(4, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check32("divu_lo_const", LO, 32'h5555_5554);
    check32("divu_hi_const", HI, 32'd2);

    issue_start(3, -32'sd7, 32'd2);
    wait_idle();
    check32("div_lo_const", LO, 32'hFFFF_FFFD);
    check32("div_hi_const", HI, 32'hFFFF_FFFF);

    move_to(5, 32'h11);
    move_to(6, 32'h22);
    issue_start(3, 32'd1234, 32'd0);
    wait_idle();
    check32("div0_hi_const", HI, 32'h11);
    check32("div0_lo_const", LO, 32'h22);

    issue_start(3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check32("ovf_lo_const", LO, 32'h8000_0000);
    check32("ovf_hi_const", HI, 32'd0);

    // Requests during BUSY are ignored
    issue_start(3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; MDOp = 4'd1; A = 32'hDEAD_BEEF; B = 32'd9;
    @(negedge clk);
    start = 1'b0; MDOp = 4'd6; A = 32'd5;
    @(negedge clk);
    MDOp = 4'd0;
    wait_idle();
    check32("ignored_lo", LO, 32'd14);
    check32("ignored_hi", HI, 32'd2);

    // Reset in busy cycle 3 of a mult
    issue_start(1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_hi", HI, 32'd0);
    check32("abort_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check32("abort_late_busy", {31'd0, busy}, 32'd0);
    check32("abort_late_hi", HI, 32'd0);
    check32("abort_late_lo", LO, 32'd0);

    // madd/maddu
    move_to(5, 32'd0);
    move_to(6, 32'hFFFF_FFFF);
`ifdef MD_UNIT_MADD_EN
    issue_start(8, 32'd1, 32'd1);
    wait_idle();
    check32("maddu_hi_const", HI, 32'd1);
    check32("maddu_lo_const", LO, 32'd0);
`else
    @(negedge clk);
    start = 1'b1; MDOp = 4'd8; A = 32'd1; B = 32'd1;
    @(negedge clk);
    start = 1'b0; MDOp = 4'd0;
    check32("maddu_off_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check32("maddu_off_busy2", {31'd0, busy}, 32'd0);
    check32("maddu_off_hi", HI, 32'd0);
    check32("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

    // Random traffic
    for (int i = 0; i < 30; i++) begin
`ifdef MD_UNIT_MADD_EN
      op = $urandom_range(1, 8);
`else
      op = $urandom_range(1, 6);
`endif
      ra = $urandom();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      if (op == 5 || op == 6) begin
        move_to(op, ra);
      end else begin
        issue_start(op, ra, rb);
        wait_idle();
      end
    end

    repeat (3) @(negedge clk);
    check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_md_unit
`default_nettype wire
